// File: rtl/noice_pkg.sv
// noice shared definitions
// tx state encoding, requester ids, defaults
package noice_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  localparam logic REQ_MON = 1'b0;
  localparam logic REQ_EVT = 1'b1;

  localparam int DEF_OVERSAMPLE = 16;
  localparam int DEF_LOCK_TMO   = 32;

endpackage

// File: rtl/noice_tx_ser.sv
// noice 8N1 serializer
// frame FSM, shift register, phase counter, registered txd
module noice_tx_ser
  import noice_pkg::*;
#(
  parameter int OVERSAMPLE = DEF_OVERSAMPLE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clke,
  input  logic       load,
  input  logic [7:0] data,
  output logic       txd,
  output logic       busy,
  output logic       idle
);

  localparam int PW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [PW-1:0] PH_LAST = PW'(OVERSAMPLE - 1);

  tx_state_e     st_q, st_d;
  logic [PW-1:0] ph_q, ph_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic          txd_q, txd_d;
  logic          tick;

  // last oversample pulse of the current bit period
  assign tick = clke && (ph_q == PH_LAST);

  // next state, shift and line level
  always_comb begin
    st_d  = st_q;
    ph_d  = ph_q;
    bit_d = bit_q;
    sh_d  = sh_q;
    txd_d = txd_q;
    if (clke) begin
      ph_d = tick ? '0 : ph_q + 1'b1;
    end
    unique case (st_q)
      ST_IDLE: begin
        ph_d  = '0;
        bit_d = '0;
        txd_d = 1'b1;
        if (load) begin
          st_d  = ST_START;
          sh_d  = data;
          txd_d = 1'b0;
        end
      end
      ST_START: begin
        if (tick) begin
          st_d  = ST_DATA;
          txd_d = sh_q[0];
        end
      end
      ST_DATA: begin
        if (tick) begin
          sh_d = {1'b1, sh_q[7:1]};
          if (bit_q == 3'd7) begin
            st_d  = ST_STOP;
            txd_d = 1'b1;
          end else begin
            bit_d = bit_q + 3'd1;
            txd_d = sh_q[1];
          end
        end
      end
      ST_STOP: begin
        if (tick) begin
          st_d = ST_IDLE;
        end
      end
      default: st_d = ST_IDLE;
    endcase
  end

  // state registers, line idles high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q  <= ST_IDLE;
      ph_q  <= '0;
      bit_q <= '0;
      sh_q  <= '0;
      txd_q <= 1'b1;
    end else begin
      st_q  <= st_d;
      ph_q  <= ph_d;
      bit_q <= bit_d;
      sh_q  <= sh_d;
      txd_q <= txd_d;
    end
  end

  assign txd  = txd_q;
  assign busy = (st_q != ST_IDLE);
  assign idle = (st_q == ST_IDLE);

endmodule

// File: rtl/noice_tx_arb.sv
// noice remote-link tx arbiter
// round-robin between monitor and event streams with packet lock
module noice_tx_arb
  import noice_pkg::*;
#(
  parameter int OVERSAMPLE = DEF_OVERSAMPLE,
  parameter int LOCK_TMO   = DEF_LOCK_TMO
) (
  input  logic       I_CLK,
  input  logic       I_RESET,
  input  logic       I_CLKE,
  input  logic [7:0] I_MON_DATA,
  input  logic       I_MON_VALID,
  input  logic       I_MON_LAST,
  output logic       O_MON_READY,
  input  logic [7:0] I_EVT_DATA,
  input  logic       I_EVT_VALID,
  input  logic       I_EVT_LAST,
  output logic       O_EVT_READY,
  output logic       O_TXD,
  output logic       O_BUSY,
  output logic [1:0] O_OWNER
);

  localparam int PW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int TW = (LOCK_TMO > 1) ? $clog2(LOCK_TMO) : 1;
  localparam logic [PW-1:0] PH_LAST  = PW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(LOCK_TMO - 1);

  logic          en_q, en_d;
  logic          lock_q, lock_d;
  logic          own_q, own_d;
  logic          last_q, last_d;
  logic [PW-1:0] tph_q, tph_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          idle, sel, sel_v, own_v, grant;
  logic          acc_last;
  logic [7:0]    acc_data;

  assign own_v = own_q ? I_EVT_VALID : I_MON_VALID;

  // pick one requester: lock owner, else round-robin
  always_comb begin
    sel   = REQ_MON;
    sel_v = 1'b0;
    if (lock_q) begin
      sel   = own_q;
      sel_v = own_v;
    end else if (I_MON_VALID && I_EVT_VALID) begin
      sel   = ~last_q;
      sel_v = 1'b1;
    end else if (I_MON_VALID) begin
      sel   = REQ_MON;
      sel_v = 1'b1;
    end else if (I_EVT_VALID) begin
      sel   = REQ_EVT;
      sel_v = 1'b1;
    end
  end

  assign grant       = en_q && idle && sel_v;
  assign O_MON_READY = grant && (sel == REQ_MON);
  assign O_EVT_READY = grant && (sel == REQ_EVT);
  assign acc_data    = sel ? I_EVT_DATA : I_MON_DATA;
  assign acc_last    = sel ? I_EVT_LAST : I_MON_LAST;

  // grant history, packet lock and stall timeout
  always_comb begin
    en_d   = 1'b1;
    lock_d = lock_q;
    own_d  = own_q;
    last_d = last_q;
    tph_d  = tph_q;
    tcnt_d = tcnt_q;
    if (grant) begin
      last_d = sel;
      lock_d = ~acc_last;
      own_d  = acc_last ? REQ_MON : sel;
      tph_d  = '0;
      tcnt_d = '0;
    end else if (!lock_q) begin
      tph_d  = '0;
      tcnt_d = '0;
    end else if (idle && !own_v && I_CLKE) begin
      if (tph_q == PH_LAST) begin
        tph_d = '0;
        if (tcnt_q == TMO_LAST) begin
          lock_d = 1'b0;
          own_d  = REQ_MON;
          tcnt_d = '0;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end else begin
        tph_d = tph_q + 1'b1;
      end
    end
  end

  // arbiter registers; evt counts as last grant so mon wins first
  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET) begin
      en_q   <= 1'b0;
      lock_q <= 1'b0;
      own_q  <= REQ_MON;
      last_q <= REQ_EVT;
      tph_q  <= '0;
      tcnt_q <= '0;
    end else begin
      en_q   <= en_d;
      lock_q <= lock_d;
      own_q  <= own_d;
      last_q <= last_d;
      tph_q  <= tph_d;
      tcnt_q <= tcnt_d;
    end
  end

  noice_tx_ser #(
    .OVERSAMPLE(OVERSAMPLE)
  ) u_ser (
    .clk  (I_CLK),
    .rst  (I_RESET),
    .clke (I_CLKE),
    .load (grant),
    .data (acc_data),
    .txd  (O_TXD),
    .busy (O_BUSY),
    .idle (idle)
  );

  assign O_OWNER = {lock_q, own_q};

endmodule

// File: tb/tb_noice_tx_arb.sv
// noice_tx_arb bench: directed scenarios plus random traffic
// checked each cycle against a pulse-counting frame model
module tb_noice_tx_arb;

  localparam int OS    = 16;
  localparam int TMO   = 32;
  localparam int FRAME = 10 * OS;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clke = 1'b0;
  logic [7:0] md = '0, ed = '0;
  logic       mv = 1'b0, ev = 1'b0, ml = 1'b0, el = 1'b0;
  logic       mrdy, erdy, txd, busy;
  logic [1:0] owner;

  noice_tx_arb #(.OVERSAMPLE(OS), .LOCK_TMO(TMO)) dut (
    .I_CLK(clk), .I_RESET(rst), .I_CLKE(clke),
    .I_MON_DATA(md), .I_MON_VALID(mv), .I_MON_LAST(ml),
    .O_MON_READY(mrdy),
    .I_EVT_DATA(ed), .I_EVT_VALID(ev), .I_EVT_LAST(el),
    .O_EVT_READY(erdy),
    .O_TXD(txd), .O_BUSY(busy), .O_OWNER(owner)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0, n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- stimulus driver ----------------
  logic [8:0] mq[$], eq[$];
  int  cyc = 0;
  int  ck_mode = 0;
  bit  gaps = 0;
  bit  acc_m = 0, acc_e = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (acc_m && mq.size() > 0) void'(mq.pop_front());
    if (acc_e && eq.size() > 0) void'(eq.pop_front());
    acc_m = 0;
    acc_e = 0;
    mv = (mq.size() > 0) && (!gaps || $urandom_range(3) != 0);
    ev = (eq.size() > 0) && (!gaps || $urandom_range(3) != 0);
    if (mv) begin md = mq[0][7:0]; ml = mq[0][8]; end
    else begin md = 8'($urandom); ml = 1'($urandom); end
    if (ev) begin ed = eq[0][7:0]; el = eq[0][8]; end
    else begin ed = 8'($urandom); el = 1'($urandom); end
    case (ck_mode)
      0: clke = 1'b1;
      1: clke = (cyc % 4 == 0);
      default: clke = ($urandom_range(2) != 0);
    endcase
  end

  // ---------------- behavioural model ----------------
  bit         busy_m, en_m, lock_m, own_m, last_m;
  int         n_m, idle_p;
  logic [7:0] byte_m;
  logic [8:0] mlog[$];
  logic [1:0] mp, cp;

  // {selected valid, requester} the rules choose right now
  function automatic logic [1:0] pick();
    if (!en_m || busy_m) return 2'b00;
    if (lock_m) return {(own_m ? ev : mv), own_m};
    if (mv && ev) return {1'b1, ~last_m};
    if (mv) return 2'b10;
    if (ev) return 2'b11;
    return 2'b00;
  endfunction

  // line level from the pulse count since acceptance
  function automatic logic exp_txd();
    int k;
    if (!busy_m) return 1'b1;
    k = n_m / OS;
    if (k == 0) return 1'b0;
    if (k <= 8) return byte_m[k-1];
    return 1'b1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_m = 0; en_m = 0; lock_m = 0; own_m = 0; last_m = 1;
      n_m = 0; idle_p = 0;
    end else begin
      mp = pick();
      if (busy_m) begin
        if (clke) n_m++;
        if (n_m == FRAME) busy_m = 0;
      end else if (mp[1]) begin
        byte_m = mp[0] ? ed : md;
        lock_m = !(mp[0] ? el : ml);
        own_m  = lock_m ? mp[0] : 1'b0;
        last_m = mp[0];
        busy_m = 1; n_m = 0; idle_p = 0;
        mlog.push_back({mp[0], byte_m});
      end else if (lock_m) begin
        if (clke) idle_p++;
        if (idle_p == TMO * OS) begin
          lock_m = 0; own_m = 0; idle_p = 0;
        end
      end
      en_m = 1;
    end
  end

  // per-cycle compare: {txd, busy, owner, mon_ready, evt_ready}
  always @(negedge clk) begin
    if (!rst) begin
      cp = pick();
      chk("outputs", {txd, busy, owner, mrdy, erdy},
          {exp_txd(), busy_m, lock_m, own_m,
           cp[1] & ~cp[0], cp[1] & cp[0]});
    end
  end

  // ---------------- timing monitor ----------------
  int  fq[$], tq[$];
  int  busy_cyc = 0, eacc_cyc = 0;
  bit  lock_seen = 0;
  logic busy_p = 1'b0, txd_p = 1'b1;

  always @(negedge clk) begin
    if (busy_p && !busy) fq.push_back(cyc);
    if (busy) busy_cyc++;
    if (owner[1]) lock_seen = 1;
    if (txd != txd_p) tq.push_back(cyc);
    if (mv && mrdy) acc_m = 1;
    if (ev && erdy) begin acc_e = 1; eacc_cyc = cyc; end
    busy_p = busy;
    txd_p  = txd;
  end

  // ---------------- helpers ----------------
  task automatic rst_on();
    @(posedge clk); #2;
    rst = 1'b1;
  endtask

  task automatic rst_off();
    repeat (2) @(posedge clk);
    fq.delete(); tq.delete();
    busy_cyc = 0; lock_seen = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int quiet = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #2;
      if (mq.size() == 0 && eq.size() == 0 && !busy) quiet++;
      else quiet = 0;
      if (quiet == 4) break;
    end
    chk({name, "_done"}, quiet, 4);
  endtask

  task automatic wait_busy(input string name);
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #2;
      if (busy) break;
    end
    chk({name, "_start"}, busy, 1);
  endtask

  int base, good;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // single mon byte 0x55, checked held through reset
    rst_on();
    mq.push_back({1'b1, 8'h55});
    repeat (2) @(posedge clk);
    #2;
    chk("rst_txd", txd, 1);
    chk("rst_busy", busy, 0);
    chk("rst_owner", owner, 0);
    chk("rst_mon_ready", mrdy, 0);
    chk("rst_evt_ready", erdy, 0);
    base = mlog.size();
    rst_off();
    #1;
    chk("first_cycle_ready", mrdy, 0);
    wait_done("t028", 400);
    chk("t028_busy_cycles", busy_cyc, FRAME);
    chk("t028_edges", tq.size(), 10);
    good = 0;
    for (int i = 1; i < tq.size(); i++)
      if (tq[i] - tq[i-1] == OS) good++;
    chk("t028_bit_len", good, 9);
    chk("t028_lock_seen", lock_seen, 0);
    chk("t028_log_len", mlog.size() - base, 1);
    if (mlog.size() > base) chk("t028_byte", mlog[base], 'h055);

    // both valid from reset: 0xA1 then 0xB2 back to back
    rst_on();
    mq.push_back({1'b1, 8'hA1});
    eq.push_back({1'b1, 8'hB2});
    base = mlog.size();
    rst_off();
    wait_done("t029", 800);
    chk("t029_log_len", mlog.size() - base, 2);
    if (mlog.size() >= base + 2) begin
      chk("t029_first", mlog[base], 'h0A1);
      chk("t029_second", mlog[base+1], 'h1B2);
    end
    if (fq.size() > 0) chk("t029_gap", eacc_cyc - fq[0], 0);
    else chk("t029_fall_seen", fq.size(), 1);

    // mon packet 0x10,0x11 keeps evt waiting
    rst_on();
    mq.push_back({1'b0, 8'h10});
    mq.push_back({1'b1, 8'h11});
    eq.push_back({1'b1, 8'hE5});
    base = mlog.size();
    rst_off();
    wait_busy("t030");
    chk("t030_owner_locked", owner, 2'b10);
    wait_done("t030", 1000);
    chk("t030_log_len", mlog.size() - base, 3);
    if (mlog.size() >= base + 3) begin
      chk("t030_b0", mlog[base], 'h010);
      chk("t030_b1", mlog[base+1], 'h011);
      chk("t030_b2", mlog[base+2], 'h1E5);
    end
    chk("t030_owner_end", owner, 0);

    // stalled lock released after 32 bit periods
    rst_on();
    mq.push_back({1'b0, 8'h20});
    eq.push_back({1'b1, 8'h33});
    base = mlog.size();
    rst_off();
    wait_done("t031", 1500);
    chk("t031_log_len", mlog.size() - base, 2);
    if (mlog.size() >= base + 2) chk("t031_evt", mlog[base+1], 'h133);
    if (fq.size() > 0) chk("t031_tmo_gap", eacc_cyc - fq[0], 512);
    else chk("t031_fall_seen", fq.size(), 1);
    chk("t031_owner_end", owner, 0);

    // reset during data bit 3 of 0xFF
    rst_on();
    mq.push_back({1'b1, 8'hFF});
    rst_off();
    wait_busy("t032");
    repeat (69) @(posedge clk);
    #1;
    chk("t032_busy_before", busy, 1);
    #1;
    rst = 1'b1;
    #1;
    chk("t032_txd", txd, 1);
    chk("t032_busy", busy, 0);
    chk("t032_owner", owner, 0);
    base = mlog.size();
    rst_off();
    repeat (300) @(posedge clk);
    chk("t032_no_resend", busy_cyc, 0);
    chk("t032_log", mlog.size() - base, 0);

    // slow enable: 0x3C with one pulse per 4 clocks
    rst_on();
    ck_mode = 1;
    mq.push_back({1'b1, 8'h3C});
    rst_off();
    wait_done("t033", 1200);
    chk("t033_edges", tq.size(), 4);
    if (tq.size() >= 4) begin
      chk("t033_four_bits", tq[2] - tq[1], 4 * 64);
      chk("t033_two_bits", tq[3] - tq[2], 2 * 64);
    end

    // random traffic, random enable and valid gaps
    rst_on();
    ck_mode = 2;
    gaps = 1;
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(1) == 0)
        mq.push_back({1'($urandom_range(3) != 0), 8'($urandom)});
      else
        eq.push_back({1'($urandom_range(3) != 0), 8'($urandom)});
    end
    base = mlog.size();
    rst_off();
    wait_done("rand", 30000);
    chk("rand_log_len", mlog.size() - base, 24);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
